// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file widths and write-arbiter state encoding.
// Imported by the arbiter top and its round-robin sub-module.
package regfile_write_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps.
// Ports: req in, ptr in; gnt (one-hot), gnt_idx, any_gnt out.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               any_gnt
);

    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any_gnt && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = PTR_W'(j);
                any_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-fill sweep, then round-robin writeback.
// Ports: cclk/rstb, clear_req, req_valid/addr/data, req_ready, rf_write*, init_done.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W
) (
    input  logic                      cclk,
    input  logic                      rstb,
    input  logic                      clear_req,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_write,
    output logic [ADDR_W-1:0]         rf_write_reg,
    output logic [DATA_W-1:0]         rf_write_data,
    output logic                      init_done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t              state, state_n;
    logic [ADDR_W:0]     init_addr, init_addr_n;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_n;
    logic                rf_write_n;
    logic [ADDR_W-1:0]   rf_write_reg_n;
    logic [DATA_W-1:0]   rf_write_data_n;

    logic [NUM_REQ-1:0]  gnt;
    logic [PTR_W-1:0]    gnt_idx;
    logic                any_gnt;
    logic                run_ok;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // clear_req outranks every requester in the cycle it is raised
    assign run_ok    = (state == ST_RUN) && !clear_req;
    assign req_ready = run_ok ? gnt : '0;
    assign init_done = (state == ST_RUN);

    assign sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    always_comb begin
        state_n         = state;
        init_addr_n     = init_addr;
        rr_ptr_n        = rr_ptr;
        rf_write_n      = 1'b0;
        rf_write_reg_n  = rf_write_reg;
        rf_write_data_n = rf_write_data;
        unique case (state)
            ST_INIT: begin
                // MSB set means all RF_DEPTH addresses have been issued
                if (init_addr[ADDR_W]) begin
                    state_n = ST_RUN;
                end else begin
                    rf_write_n      = 1'b1;
                    rf_write_reg_n  = init_addr[ADDR_W-1:0];
                    rf_write_data_n = '0;
                    init_addr_n     = init_addr + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_n     = ST_INIT;
                    init_addr_n = '0;
                end else if (any_gnt) begin
                    // r0 is hardwired zero: acknowledge, do not write
                    rf_write_n      = |sel_addr;
                    rf_write_reg_n  = sel_addr;
                    rf_write_data_n = sel_data;
                    rr_ptr_n = (gnt_idx == PTR_W'(NUM_REQ-1))
                             ? '0 : gnt_idx + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state         <= ST_INIT;
            init_addr     <= '0;
            rr_ptr        <= '0;
            rf_write      <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else begin
            state         <= state_n;
            init_addr     <= init_addr_n;
            rr_ptr        <= rr_ptr_n;
            rf_write      <= rf_write_n;
            rf_write_reg  <= rf_write_reg_n;
            rf_write_data <= rf_write_data_n;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized self-checking bench for regfile_write_arbiter.
// Reference model: sweep counter, round-robin pointer, pending requesters, RF image.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            cclk = 1'b0;
    logic            rstb = 1'b0;
    logic            clear_req = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            rf_write;
    logic [AW-1:0]   rf_write_reg;
    logic [DW-1:0]   rf_write_data;
    logic            init_done;

    int total = 0;
    int bad   = 0;

    bit          m_run;
    int          m_cnt;
    int          m_ptr;
    bit          e_we;
    int unsigned e_reg;
    logic [31:0] e_data;
    bit          pend [N];
    logic [4:0]  paddr [N];
    logic [31:0] pdata [N];
    logic [31:0] m_mem [32];
    logic [31:0] s_mem [32];
    logic [N-1:0] last_ready;

    regfile_write_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .cclk          (cclk),
        .rstb          (rstb),
        .clear_req     (clear_req),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rf_write      (rf_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .init_done     (init_done)
    );

    always #5 cclk = ~cclk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        int j;
        if (!m_run) return -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_cnt  = 0;
        m_ptr  = 0;
        e_we   = 0;
        e_reg  = 0;
        e_data = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
    endtask

    task automatic post(input int i, input logic [4:0] a, input logic [31:0] d);
        pend[i]  = 1;
        paddr[i] = a;
        pdata[i] = d;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_we"},   rf_write,      e_we);
        check({tag, "_reg"},  rf_write_reg,  e_reg);
        check({tag, "_data"}, rf_write_data, e_data);
        check({tag, "_done"}, init_done,     m_run);
    endtask

    task automatic tick(input bit clr);
        int g;
        logic [N-1:0] er;
        @(negedge cclk);
        clear_req = clr;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_addr[i*AW +: AW]  = paddr[i];
            req_data[i*DW +: DW]  = pdata[i];
        end
        #1;
        g  = clr ? -1 : model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("ready", req_ready, er);
        last_ready = req_ready;
        @(posedge cclk);
        #1;
        if (!m_run) begin
            if (m_cnt < 32) begin
                e_we   = 1;
                e_reg  = m_cnt;
                e_data = '0;
                m_mem[m_cnt] = '0;
                m_cnt++;
            end else begin
                e_we  = 0;
                m_run = 1;
            end
        end else if (clr) begin
            e_we  = 0;
            m_run = 0;
            m_cnt = 0;
        end else if (g >= 0) begin
            e_reg  = paddr[g];
            e_data = pdata[g];
            e_we   = (paddr[g] != 0);
            if (e_we) m_mem[e_reg] = e_data;
            m_ptr   = (g + 1) % N;
            pend[g] = 0;
        end else begin
            e_we = 0;
        end
        check_outputs("cyc");
        if (rf_write) s_mem[rf_write_reg] = rf_write_data;
        clear_req = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 8; k++) begin
            if (pend[0] || pend[1] || pend[2]) tick(0);
        end
    endtask

    initial begin
        logic [N-1:0] rr_exp [4];
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            s_mem[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            paddr[i] = '0;
            pdata[i] = '0;
        end
        model_reset();

        repeat (2) @(posedge cclk);
        #1;
        check("rst_we",    rf_write,      1'b0);
        check("rst_reg",   rf_write_reg,  '0);
        check("rst_data",  rf_write_data, '0);
        check("rst_done",  init_done,     1'b0);
        check("rst_ready", req_ready,     '0);
        rstb = 1'b1;

        for (int k = 0; k < 32; k++) begin
            tick(0);
            check("sweep_reg", rf_write_reg, k);
            check("sweep_we",  rf_write,     1'b1);
        end
        tick(0);
        check("sweep_done", init_done, 1'b1);
        check("sweep_end",  rf_write,  1'b0);

        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) post(i, 5'(i + 1), $urandom);
            tick(0);
            check("rr_seq", last_ready, rr_exp[c]);
            check("rr_we",  rf_write,   1'b1);
        end
        drain();

        post(1, 5'd5, 32'hDEADBEEF);
        tick(0);
        check("single_ready", last_ready,    3'b010);
        check("single_we",    rf_write,      1'b1);
        check("single_reg",   rf_write_reg,  5'd5);
        check("single_data",  rf_write_data, 32'hDEADBEEF);

        post(0, 5'd0, 32'h1234);
        tick(0);
        check("r0_ready", last_ready, 3'b001);
        check("r0_we",    rf_write,   1'b0);
        for (int i = 0; i < N; i++) post(i, 5'(10 + i), $urandom);
        tick(0);
        check("r0_ptr_adv", last_ready, 3'b010);
        drain();

        post(0, 5'd7, 32'h55);
        tick(1);
        check("clr_ready", last_ready, '0);
        check("clr_done",  init_done,  1'b0);
        check("clr_we",    rf_write,   1'b0);
        tick(0);
        check("clr_restart", rf_write_reg, 5'd0);
        check("clr_restart_we", rf_write, 1'b1);
        for (int k = 0; k < 10; k++) tick(0);
        check("at_addr10", rf_write_reg, 5'd10);

        #2;
        rstb = 1'b0;
        #1;
        check("arst_we",    rf_write,     1'b0);
        check("arst_reg",   rf_write_reg, '0);
        check("arst_done",  init_done,    1'b0);
        check("arst_ready", req_ready,    '0);
        model_reset();
        @(posedge cclk);
        #1;
        rstb = 1'b1;
        tick(0);
        check("arst_restart", rf_write_reg, 5'd0);
        check("arst_restart_we", rf_write, 1'b1);
        for (int k = 0; k < 32; k++) tick(0);

        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    if ($urandom_range(0, 7) == 0)
                        post(i, 5'd0, $urandom);
                    else
                        post(i, 5'($urandom_range(0, 31)), $urandom);
                end
            end
            tick($urandom_range(0, 79) == 0);
        end
        for (int k = 0; k < 40; k++) tick(0);

        for (int r = 0; r < 32; r++) check("mem", s_mem[r], m_mem[r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
